// File: rtl/iq_amp_fifo.sv
// Amplitude scaler + show-ahead FIFO + frame marker for the CORDIC modulator output.
// Optional macro IQ_AMP_ROUND_EN: round half up instead of truncating on the >>>16.
module iq_amp_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [31:0]              in_i,
    input  logic [31:0]              in_r,
    input  logic [15:0]              amp,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [31:0]              out_i,
    output logic [31:0]              out_r,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned FW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned PW  = 49;

`ifdef IQ_AMP_ROUND_EN
    localparam logic signed [PW-1:0] RND = 49'sh8000;
`else
    localparam logic signed [PW-1:0] RND = 49'sh0;
`endif

    logic signed [PW-1:0] p_i, p_r, q_i, q_r;
    logic [31:0]          y_i, y_r;
    logic                 s_vld;
    logic [31:0]          s_i, s_r;
    logic [63:0]          mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [FW-1:0]        frame_cnt;
    logic                 push, pop, acc;
    logic [63:0]          head;
    logic                 unused_bits;

    // Signed Q16.16 times unsigned Q0.16, rescaled back to Q16.16
    always_comb begin
        p_i = $signed({{17{in_i[31]}}, in_i}) * $signed({33'b0, amp});
        p_r = $signed({{17{in_r[31]}}, in_r}) * $signed({33'b0, amp});
        q_i = p_i + RND;
        q_r = p_r + RND;
        y_i = q_i[47:16];
        y_r = q_r[47:16];
    end

    assign unused_bits = ^{q_i[48], q_i[15:0], q_r[48], q_r[15:0]};

    // Space is reserved for the sample sitting in the scale stage
    assign in_rdy  = (CW1'(fifo_cnt) + CW1'(s_vld)) < CW1'(DEPTH);
    assign acc     = in_vld & in_rdy;
    assign push    = s_vld;
    assign out_vld = (fifo_cnt != '0);
    assign pop     = out_vld & out_rdy;

    assign head     = mem[rd_ptr];
    assign out_i    = out_vld ? head[63:32] : 32'h0;
    assign out_r    = out_vld ? head[31:0]  : 32'h0;
    assign out_last = out_vld & (frame_cnt == FW'(FRAME_LEN - 1));

    // Scale stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld <= 1'b0;
            s_i   <= 32'h0;
            s_r   <= 32'h0;
        end else begin
            s_vld <= acc;
            if (acc) begin
                s_i <= y_i;
                s_r <= y_r;
            end
        end
    end

    // Storage is not reset; out_vld masks stale contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_i, s_r};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Beat position within the current output frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (pop) begin
            if (frame_cnt == FW'(FRAME_LEN - 1)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_iq_amp_fifo.sv
// Randomized bench for iq_amp_fifo against a queue-based reference model.
module tb_iq_amp_fifo;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned FRAME_LEN = 16;

`ifdef IQ_AMP_ROUND_EN
    localparam longint RND_TB = 64'sd32768;
`else
    localparam longint RND_TB = 64'sd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_i;
    logic [31:0] in_r;
    logic [15:0] amp;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_i;
    logic [31:0] out_r;
    logic        out_last;
    logic [3:0]  fifo_cnt;

    iq_amp_fifo #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_i     (in_i),
        .in_r     (in_r),
        .amp      (amp),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_i    (out_i),
        .out_r    (out_r),
        .out_last (out_last),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: every sample accepted but not yet delivered, oldest first
    logic [63:0] q[$];
    logic        last_acc = 1'b0;
    int          beats    = 0;
    int          n_acc    = 0;
    int          fb       = 0;
    int          lasts[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] scale(input logic [31:0] x, input logic [15:0] a);
        longint p;
        p = longint'($signed(x)) * longint'(a);
        p = (p + RND_TB) >>> 16;
        return 32'(p);
    endfunction

    function automatic int exp_cnt();
        return q.size() - int'(last_acc);
    endfunction

    function automatic logic exp_vld();
        return exp_cnt() != 0;
    endfunction

    function automatic logic exp_last();
        return exp_vld() && ((beats % FRAME_LEN) == FRAME_LEN - 1);
    endfunction

    task automatic check_outputs();
        logic [63:0] h;
        check("in_rdy", 64'(in_rdy), 64'(q.size() < DEPTH));
        check("fifo_cnt", 64'(fifo_cnt), 64'(exp_cnt()));
        check("out_vld", 64'(out_vld), 64'(exp_vld()));
        if (exp_vld()) begin
            h = q[0];
            check("out_i", 64'(out_i), 64'(h[63:32]));
            check("out_r", 64'(out_r), 64'(h[31:0]));
        end else begin
            check("out_i_idle", 64'(out_i), 64'h0);
            check("out_r_idle", 64'(out_r), 64'h0);
        end
        check("out_last", 64'(out_last), 64'(exp_last()));
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1
    task automatic step();
        logic acc, pop;
        @(negedge clk);
        check_outputs();
        acc = in_vld && (q.size() < DEPTH);
        pop = exp_vld() && out_rdy;
        if (pop && out_last) lasts.push_back(fb + 1);
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            beats++;
            fb++;
        end
        if (acc) begin
            q.push_back({scale(in_i, amp), scale(in_r, amp)});
            n_acc++;
        end
        last_acc = acc;
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        last_acc = 1'b0;
        beats    = 0;
    endtask

    // Asynchronous reset asserted away from the clock edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_out_vld", 64'(out_vld), 64'h0);
        check("rst_fifo_cnt", 64'(fifo_cnt), 64'h0);
        check("rst_in_rdy", 64'(in_rdy), 64'h1);
        check("rst_out_last", 64'(out_last), 64'h0);
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        in_i = $urandom();
        in_r = $urandom();
        amp  = 16'($urandom());
    endtask

    initial begin
        int a0, b0;
        bit done;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_i    = '0;
        in_r    = '0;
        amp     = '0;
        #1;
        check("init_out_vld", 64'(out_vld), 64'h0);
        check("init_in_rdy", 64'(in_rdy), 64'h1);
        check("init_fifo_cnt", 64'(fifo_cnt), 64'h0);
        check("init_out_i", 64'(out_i), 64'h0);
        check("init_out_r", 64'(out_r), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unity-half scale and two-cycle latency
        in_vld = 1'b1; in_i = 32'h0001_0000; in_r = 32'hFFFF_0000; amp = 16'h8000;
        out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        check("lat_e0_vld", 64'(out_vld), 64'h0);
        step();
        check("lat_e1_vld", 64'(out_vld), 64'h1);
        check("half_i", 64'(out_i), 64'h0000_8000);
        check("half_r", 64'(out_r), 64'hFFFF_8000);
        repeat (2) step();

        // Rounding of the smallest magnitudes
        in_vld = 1'b1; in_i = 32'h0000_0001; in_r = 32'hFFFF_FFFF; amp = 16'h8000;
        step();
        in_vld = 1'b0;
        step();
`ifdef IQ_AMP_ROUND_EN
        check("rnd_i", 64'(out_i), 64'h0000_0001);
        check("rnd_r", 64'(out_r), 64'h0000_0000);
`else
        check("rnd_i", 64'(out_i), 64'h0000_0000);
        check("rnd_r", 64'(out_r), 64'hFFFF_FFFF);
`endif
        repeat (2) step();

        // Backpressure until full, then drain in order
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        a0 = n_acc;
        repeat (12) begin rand_in(); step(); end
        check("full_accepted", 64'(n_acc - a0), 64'd8);
        check("full_in_rdy", 64'(in_rdy), 64'h0);
        check("full_fifo_cnt", 64'(fifo_cnt), 64'd8);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        b0 = beats;
        repeat (12) step();
        check("drain_beats", 64'(beats - b0), 64'd8);
        check("drain_fifo_cnt", 64'(fifo_cnt), 64'h0);

        // Simultaneous push and pop at DEPTH-1, then wrap the pointers
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        a0 = n_acc;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            rand_in();
            step();
            done = (n_acc - a0) >= 8;
        end
        if (!done) check("pp_timeout", 64'h0, 64'h1);
        check("pp_pre_cnt", 64'(fifo_cnt), 64'd7);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        step();
        check("pp_cnt_hold", 64'(fifo_cnt), 64'd7);
        for (int k = 0; k < 60; k++) begin
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            rand_in();
            step();
        end

        // Framing over 40 samples with random stalls
        do_reset();
        fb = 0;
        lasts.delete();
        a0 = n_acc;
        in_vld = 1'b1;
        for (int k = 0; k < 400 && (n_acc - a0) < 40; k++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            rand_in();
            step();
        end
        in_vld = 1'b0;
        for (int k = 0; k < 400 && q.size() != 0; k++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        check("frame_drained", 64'(q.size()), 64'h0);
        check("frame_beats", 64'(fb), 64'd40);
        check("frame_nlast", 64'(lasts.size()), 64'd2);
        check("frame_last0", 64'(lasts.size() > 0 ? lasts[0] : 0), 64'd16);
        check("frame_last1", 64'(lasts.size() > 1 ? lasts[1] : 0), 64'd32);

        // Reset mid-stream with 5 queued at frame beat 10
        do_reset();
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        for (int k = 0; k < 100 && beats < 10; k++) begin rand_in(); step(); end
        out_rdy = 1'b0;
        for (int k = 0; k < 100 && q.size() < 5; k++) begin rand_in(); step(); end
        in_vld = 1'b0;
        step();
        check("mid_cnt", 64'(fifo_cnt), 64'd5);
        check("mid_beats", 64'(beats), 64'd10);
        do_reset();
        fb = 0;
        lasts.delete();
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        repeat (20) begin rand_in(); step(); end
        check("mid_new_last", 64'(lasts.size() > 0 ? lasts[0] : 0), 64'd16);

        // Fully random traffic
        for (int k = 0; k < 400; k++) begin
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = ($urandom_range(0, 2) != 0);
            rand_in();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iq_amp_fifo.md
# iq_amp_fifo

Downstream stage of the CORDIC modulator. Accepts each corrected sine/cosine sample pair with a valid/ready handshake and scales both components by a programmable amplitude. Buffers the scaled pairs in a small FIFO and presents them as a framed valid/ready stream with a `last` marker every FRAME_LEN samples. Its `in_rdy` drives the modulator's `rdy_i`, so backpressure propagates cleanly upstream.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- FRAME_LEN, 16, output beats per frame; ≥1
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  input sample valid; modulator `vld_o`
- in_rdy  out  1  block can accept; drives modulator `rdy_i`
- in_i  in  32  imaginary (sin) part, signed Q16.16
- in_r  in  32  real (cos) part, signed Q16.16
- amp  in  16  amplitude, unsigned Q0.16 (0xFFFF ≈ 1.0)
- out_vld  out  1  output sample valid
- out_rdy  in  1  downstream ready
- out_i  out  32  scaled imaginary, signed Q16.16
- out_r  out  32  scaled real, signed Q16.16
- out_last  out  1  high on the final beat of each frame
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **Input handshake:** an input is accepted when `in_vld & in_rdy` is high at a rising edge. `in_i`, `in_r` and `amp` are sampled together at that edge.
- **Scale stage (one register):** `p = $signed(x) * $signed({1'b0, amp})`, 49-bit signed result. `y = (p + rnd) >>> 16`, truncated to 32 bits. Overflow is impossible because amp < 1.0. `rnd` is defined under Configuration. The stage has its own valid bit `s_vld`.
- **FIFO write:** when `s_vld` is 1, the scaled pair is written at the next edge. The write is unconditional, because `in_rdy` guarantees space.
- **Ready rule:** `in_rdy = (fifo_cnt + s_vld) < DEPTH`. It is combinational from registers only and never depends on `in_vld`.
- **Output:** the FIFO is show-ahead. `out_vld = (fifo_cnt != 0)`. `out_i` and `out_r` come from the head entry. The entry is popped on `out_vld & out_rdy`.
- **Frame counter:**
  - Counts output handshakes from 0 to FRAME_LEN-1.
  - `out_last = out_vld & (frame_cnt == FRAME_LEN-1)`.
  - The counter wraps to 0 on the handshake that carries `out_last`.
  - With FRAME_LEN=1, every beat is last.
- **Simultaneous push and pop:** occupancy is unchanged and both pointers advance.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are resolved by `fifo_cnt`, not by the pointers.
- **Data stability:** while `out_vld` is high and `out_rdy` is low, `out_i`, `out_r` and `out_last` are held stable.
- **Reset values** (immediate, asynchronous):
  - `s_vld`=0, pointers=0, `fifo_cnt`=0, `frame_cnt`=0.
  - Therefore `out_vld`=0, `out_last`=0, `in_rdy`=1.
  - `out_i` and `out_r` read 0; memory is not cleared and is masked by `out_vld`=0.
- **Reset mid-operation:** all buffered and in-flight samples are discarded and the frame restarts at beat 0. Reset does not emit a partial `out_last`.

## Timing
- Input accepted at edge E0, `s_vld` set after E0, written to the FIFO at E1. `out_vld` rises in the cycle after E1, giving 2-cycle latency with an empty FIFO and `out_rdy`=1.
- Throughput is one sample per clock when `out_rdy` is held at 1.
- `in_rdy` falls in the cycle where `fifo_cnt + s_vld` reaches DEPTH. It rises again in the cycle after a pop frees space.
- No combinational path runs from `out_rdy` to `in_rdy`. This costs one cycle of bubble on refill from full.

## Configuration
- Macro: `IQ_AMP_ROUND_EN`.
- **Defined:** `rnd = 49'h8000`, i.e. round half up (toward +∞).
- **Undefined:** `rnd = 0`, i.e. arithmetic-shift truncation (toward −∞).
- Latency, handshake and ports are identical in both builds.

## Test plan
- **Unity-half scale:** `in_i`=0x00010000, `in_r`=0xFFFF0000, `amp`=0x8000, `out_rdy`=1 → `out_i`=0x00008000, `out_r`=0xFFFF8000, with `out_vld` 2 cycles after acceptance.
- **Rounding:** `in_i`=0x00000001, `in_r`=0xFFFFFFFF, `amp`=0x8000.
  - With `IQ_AMP_ROUND_EN`: `out_i`=0x00000001, `out_r`=0x00000000.
  - Without it: `out_i`=0x00000000, `out_r`=0xFFFFFFFF.
- **Backpressure/full:** hold `out_rdy`=0 and drive `in_vld`=1 continuously.
  - Exactly 8 samples are accepted and `in_rdy`=0 afterwards, with `fifo_cnt`=8.
  - Then release `out_rdy`: the 8 outputs come out in order, with no loss or duplication.
- **Framing:** stream 40 samples with random `out_rdy` stalls → `out_last` on beats 16 and 32 only. Frame data stays stable during stalls.
- **Simultaneous push/pop at fifo_cnt=DEPTH-1:** `fifo_cnt` stays 7 and the pointers wrap past entry 7 correctly.
- **Reset mid-stream:** assert `rst_n`=0 with 5 entries queued and `frame_cnt`=10.
  - Immediately: `out_vld`=0, `fifo_cnt`=0, `in_rdy`=1.
  - After release, the first new output is beat 0 of a new frame.
